// File: rtl/rst_sequencer_if.sv
// Signal bundle between the reset sequencer (master) and the logic it holds in reset (slave).
// ready is a level that stays high while running; there is no valid/ready transfer on this bundle.
interface rst_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             locked;
  logic             sys_reset;
  logic             sys_reset_n;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] lock_loss_count;

  modport master (
    input  locked,
    output sys_reset,
    output sys_reset_n,
    output ready,
    output state,
    output lock_loss_count
  );

  modport slave (
    output locked,
    input  sys_reset,
    input  sys_reset_n,
    input  ready,
    input  state,
    input  lock_loss_count
  );
endinterface

// File: rtl/rst_sequencer.sv
// Reset sequencer for the MMCM-generated clock domain: qualifies lock, holds reset for a
// settle time, then releases a synchronously-deasserted system reset; counts lock losses.
module rst_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES        = 8,
  parameter int CNT_W              = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  rst_sequencer_if.master bus
);

  localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [1:0]             rst_sync_q;
  logic                   rst_n_int;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]       loss_q, loss_d;
  logic                   sys_reset_q, sys_reset_n_q;

  // Internal reset asserts with reset_n and releases two edges after it rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // Only consumer of the raw lock flag; it keeps sampling while the FSM is still held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_sync_q <= '0;
    else          lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.locked};
  end

  assign locked_s = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      loss_q        <= '0;
      sys_reset_q   <= 1'b1;
      sys_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      loss_q        <= loss_d;
      sys_reset_q   <= (state_d != RUN);
      sys_reset_n_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.sys_reset       = sys_reset_q;
  assign bus.sys_reset_n     = sys_reset_n_q;
  assign bus.ready           = (state_q == RUN);
  assign bus.state           = state_q;
  assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: a default instance and a short-qualification, 2-bit-count instance
// share clock, reset_n and locked; a run-length reference model predicts every cycle.
module tb_rst_sequencer;

  localparam int SYNC     = 2;
  localparam int DEF_LSC  = 16;
  localparam int DEF_HOLD = 8;
  localparam int DEF_CMAX = 15;
  localparam int SML_LSC  = 1;
  localparam int SML_HOLD = 1;
  localparam int SML_CMAX = 3;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic locked  = 1'b0;

  always #5 clk = ~clk;

  rst_sequencer_if #(.CNT_W(4)) if_def ();
  rst_sequencer_if #(.CNT_W(2)) if_sml ();

  assign if_def.locked = locked;
  assign if_sml.locked = locked;

  rst_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(DEF_LSC), .HOLD_CYCLES(DEF_HOLD), .CNT_W(4)
  ) u_def (
    .clk(clk), .reset_n(reset_n), .bus(if_def)
  );

  rst_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(SML_LSC), .HOLD_CYCLES(SML_HOLD), .CNT_W(2)
  ) u_sml (
    .clk(clk), .reset_n(reset_n), .bus(if_sml)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q_def[$];
  logic [8:0] exp_q_sml[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // FSM position is the count of consecutive qualified lock samples since the last restart.
  int unsigned age;
  bit          lq[$];
  int          run_len[2];
  int          loss[2];
  bit          rst_ev = 1'b0;
  bit          model_ls;

  function automatic logic [8:0] exp_word(input int len, input int lsc, input int hold, input int cnt);
    logic [1:0] st;
    if (len == 0)                st = 2'd0;
    else if (len <= lsc)         st = 2'd1;
    else if (len <= lsc + hold)  st = 2'd2;
    else                         st = 2'd3;
    return {st, (st != 2'd3), (st == 2'd3), (st == 2'd3), 4'(cnt)};
  endfunction

  initial begin
    forever begin
      @(negedge reset_n);
      rst_ev = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n || rst_ev) begin
        rst_ev = 1'b0;
        age    = 0;
        lq     = {};
        for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
        for (int d = 0; d < 2; d++) begin
          run_len[d] = 0;
          loss[d]    = 0;
        end
        if (reset_n) begin
          void'(lq.pop_front());
          lq.push_back(locked);
          age = 1;
        end
      end else begin
        model_ls = lq.pop_front();
        lq.push_back(locked);
        if (age >= 2) begin
          for (int d = 0; d < 2; d++) begin
            int full;
            int cmax;
            full = (d == 0) ? (DEF_LSC + DEF_HOLD + 1) : (SML_LSC + SML_HOLD + 1);
            cmax = (d == 0) ? DEF_CMAX : SML_CMAX;
            if (model_ls) begin
              if (run_len[d] < full) run_len[d]++;
            end else begin
              if (run_len[d] == full) loss[d] = (loss[d] < cmax) ? loss[d] + 1 : cmax;
              run_len[d] = 0;
            end
          end
        end else begin
          age++;
        end
      end
      exp_q_def.push_back(exp_word(run_len[0], DEF_LSC, DEF_HOLD, loss[0]));
      exp_q_sml.push_back(exp_word(run_len[1], SML_LSC, SML_HOLD, loss[1]));
    end
  end

  // ---------------- monitor ----------------
  bit running = 1'b1;

  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (exp_q_def.size() == 0 || exp_q_sml.size() == 0) begin
          chk("exp_queue_empty", 1, 0);
        end else begin
          e = exp_q_def.pop_front();
          chk("def.state",       int'(if_def.state),           int'(e[8:7]));
          chk("def.sys_reset",   int'(if_def.sys_reset),       int'(e[6]));
          chk("def.sys_reset_n", int'(if_def.sys_reset_n),     int'(e[5]));
          chk("def.ready",       int'(if_def.ready),           int'(e[4]));
          chk("def.loss_count",  int'(if_def.lock_loss_count), int'(e[3:0]));
          e = exp_q_sml.pop_front();
          chk("sml.state",       int'(if_sml.state),           int'(e[8:7]));
          chk("sml.sys_reset",   int'(if_sml.sys_reset),       int'(e[6]));
          chk("sml.sys_reset_n", int'(if_sml.sys_reset_n),     int'(e[5]));
          chk("sml.ready",       int'(if_sml.ready),           int'(e[4]));
          chk("sml.loss_count",  int'(if_sml.lock_loss_count), int'(e[3:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Counts posedges until sys_reset on each instance equals want; -1 if the bound expires.
  task automatic measure_edges(input logic want, output int lat_def, output int lat_sml);
    lat_def = -1;
    lat_sml = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (lat_def < 0 && if_def.sys_reset == want) lat_def = n;
      if (lat_sml < 0 && if_sml.sys_reset == want) lat_sml = n;
      if (lat_def >= 0 && lat_sml >= 0) break;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".def.sys_reset"},   int'(if_def.sys_reset),       1);
    chk({tag, ".def.sys_reset_n"}, int'(if_def.sys_reset_n),     0);
    chk({tag, ".def.ready"},       int'(if_def.ready),           0);
    chk({tag, ".def.state"},       int'(if_def.state),           0);
    chk({tag, ".def.loss_count"},  int'(if_def.lock_loss_count), 0);
    chk({tag, ".sml.sys_reset"},   int'(if_sml.sys_reset),       1);
    chk({tag, ".sml.state"},       int'(if_sml.state),           0);
    chk({tag, ".sml.loss_count"},  int'(if_sml.lock_loss_count), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ld;
    int ls;
    int sml_sat[5];
    sml_sat = '{1, 2, 3, 3, 3};

    // Lock present before reset release: full qualification counted from reset_n rise.
    locked = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset_n = 1'b1;
    measure_edges(1'b0, ld, ls);
    chk("t1_release_lat_def", ld, 27);
    chk("t1_release_lat_sml", ls, 5);

    // Lock lost in RUN: reset re-asserts after the synchroniser plus one edge.
    repeat (3) @(negedge clk);
    locked = 1'b0;
    measure_edges(1'b1, ld, ls);
    chk("t3_loss_lat_def", ld, 3);
    chk("t3_loss_lat_sml", ls, 3);
    chk("t3_loss_cnt_def", int'(if_def.lock_loss_count), 1);
    chk("t3_loss_cnt_sml", int'(if_sml.lock_loss_count), 1);
    repeat (4) @(negedge clk);
    locked = 1'b1;
    measure_edges(1'b0, ld, ls);
    chk("t3_relock_lat_def", ld, 27);
    chk("t3_relock_lat_sml", ls, 5);

    // Glitch while the default instance is in STABLE: qualification restarts, no count.
    @(negedge clk);
    locked = 1'b0;
    repeat (5) @(negedge clk);
    locked = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    chk("t2_in_stable_def", int'(if_def.state), 1);
    @(negedge clk);
    locked = 1'b0;
    repeat (3) @(negedge clk);
    locked = 1'b1;
    measure_edges(1'b0, ld, ls);
    chk("t2_requal_lat_def", ld, 27);
    chk("t2_requal_lat_sml", ls, 5);
    chk("t2_cnt_def", int'(if_def.lock_loss_count), 2);
    chk("t2_cnt_sml", int'(if_sml.lock_loss_count), 3);

    // Asynchronous reset pulse while the default instance sits in HOLD.
    @(negedge clk);
    locked = 1'b0;
    repeat (6) @(negedge clk);
    locked = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    chk("t5_in_hold_def", int'(if_def.state), 2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("t5_async");
    #1;
    reset_n = 1'b1;
    measure_edges(1'b0, ld, ls);
    chk("t5_restart_lat_def", ld, 27);
    chk("t5_restart_lat_sml", ls, 5);

    // Five losses in RUN: the 2-bit count saturates, the 4-bit one keeps counting.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      locked = 1'b0;
      repeat (6) @(negedge clk);
      chk("t4_cnt_def", int'(if_def.lock_loss_count), i + 1);
      chk("t4_cnt_sml", int'(if_sml.lock_loss_count), sml_sat[i]);
      locked = 1'b1;
      repeat (30) @(negedge clk);
    end

    // Random lock activity, sub-cycle glitches and occasional mid-cycle reset pulses.
    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 19);
      @(negedge clk);
      if (op == 0) begin
        #1;
        reset_n = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #3;
        reset_n = 1'b1;
      end else if (op == 1) begin
        #1;
        locked = ~locked;
        #2;
        locked = ~locked;
      end else begin
        #($urandom_range(0, 3));
        locked = ($urandom_range(0, 3) != 0);
        if (locked) repeat ($urandom_range(0, 45)) @(negedge clk);
        else        repeat ($urandom_range(0, 8)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
